// File: rtl/macc_dump_quantise_pkg.sv
// Shared constants and FSM encoding for the MAC integrate-and-dump controller.
package macc_dump_quantise_pkg;

  localparam int unsigned ACC_W_DEF   = 48;
  localparam int unsigned OUT_W_DEF   = 16;
  localparam int unsigned SHIFT_DEF   = 16;
  localparam int unsigned N_W_DEF     = 16;
  localparam int unsigned MAC_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

endpackage

// File: rtl/macc_dump_quantise_round_sat.sv
// Combinational signed round-half-up right shift followed by saturation to OUT_W bits.
module macc_dump_quantise_round_sat
  import macc_dump_quantise_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [OUT_W-1:0] o_data_c,
  output logic             o_sat_c
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int unsigned EXT_W   = ACC_W + 1;
  localparam int unsigned HI_W    = EXT_W - OUT_W + 1;
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EXT_W-1:0] RND = (SHIFT > 0) ? (EXT_W'(1) << RND_POS) : '0;
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_sum;
  logic signed [EXT_W-1:0] w_shr;
  logic        [HI_W-1:0]  w_hi;

  // Round, arithmetic shift, then clip when the bits above the output sign are not all equal.
  always_comb begin
    w_ext    = {i_acc[ACC_W-1], i_acc};
    w_sum    = w_ext + $signed(RND);
    w_shr    = w_sum >>> SHIFT;
    w_hi     = w_shr[EXT_W-1:OUT_W-1];
    o_sat_c  = !((&w_hi) || !(|w_hi));
    o_data_c = w_shr[OUT_W-1:0];
    if (o_sat_c) begin
      o_data_c = w_shr[EXT_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

endmodule

// File: rtl/macc_dump_quantise.sv
// Integrate-and-dump controller: admits dump_len products into the MAC, drains its
// pipeline, captures/clears the accumulator and emits a rounded, saturated result.
module macc_dump_quantise
  import macc_dump_quantise_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned SHIFT   = SHIFT_DEF,
  parameter int unsigned N_W     = N_W_DEF,
  parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_W-1:0]   dump_len,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_acc,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned LAT_W      = $clog2(MAC_LAT + 1);
  localparam int unsigned DRAIN_INIT = (MAC_LAT >= 2) ? MAC_LAT - 2 : 0;

  state_t           r_state;
  state_t           w_next_state;
  logic [N_W-1:0]   r_count;
  logic [N_W-1:0]   r_len;
  logic [LAT_W-1:0] r_drain;
  logic             r_sample_ready;
  logic             r_mac_clr;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_sat;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic             w_set_clr;
  logic [OUT_W-1:0] w_data;
  logic             w_sat;

  macc_dump_quantise_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .i_acc    (mac_acc),
    .o_data_c (w_data),
    .o_sat_c  (w_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and control strobes; INIT after reset spends one extra cycle raising mac_clr.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_load       = 1'b0;
    w_set_clr    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_mac_clr) begin
          w_next_state = ST_ACCUM;
        end else begin
          w_set_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        w_accept = sample_valid & r_sample_ready;
        w_last   = w_accept && ((r_count + N_W'(1)) == r_len);
        if (w_last) begin
          w_next_state = (MAC_LAT > 1) ? ST_DRAIN : ST_DUMP;
        end
      end
      ST_DRAIN: begin
        if (r_drain == '0) begin
          w_next_state = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (!r_out_valid || out_ready) begin
          w_load       = 1'b1;
          w_set_clr    = 1'b1;
          w_next_state = ST_INIT;
        end
      end
      default: w_next_state = ST_INIT;
    endcase
  end

  // Counters, handshake outputs and the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= '0;
      r_len          <= N_W'(1);
      r_drain        <= '0;
      r_sample_ready <= 1'b0;
      r_mac_clr      <= 1'b0;
      r_out_data     <= '0;
      r_out_sat      <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      r_sample_ready <= (w_next_state == ST_ACCUM);
      r_mac_clr      <= w_set_clr;

      if (r_state == ST_INIT) begin
        r_count <= '0;
        r_len   <= (dump_len == '0) ? N_W'(1) : dump_len;
      end else if (w_accept) begin
        r_count <= r_count + N_W'(1);
      end

      if (w_last) begin
        r_drain <= LAT_W'(DRAIN_INIT);
      end else if ((r_state == ST_DRAIN) && (r_drain != '0)) begin
        r_drain <= r_drain - LAT_W'(1);
      end

      if (w_load) begin
        r_out_data  <= w_data;
        r_out_sat   <= w_sat;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign sample_ready = r_sample_ready;
  assign mac_clr      = r_mac_clr;
  assign out_data     = r_out_data;
  assign out_sat      = r_out_sat;
  assign out_valid    = r_out_valid;

endmodule
